// File: rtl/systolic_array_if.sv
// Operand, counter and result bundle between systolic_array and its caller.
// The slave modport is the array; the master modport is the operand/result side.
interface systolic_array_if #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 16,
  parameter int N       = 4,
  parameter int M       = 8
);
  localparam int K_W   = $clog2(M);
  localparam int BLK_W = $clog2(M / N);

  logic                   enable_row_count_A;
  logic [N*D_W-1:0]       A;
  logic [N*D_W-1:0]       B;
  logic [K_W-1:0]         pixel_cntr_A;
  logic [BLK_W-1:0]       slice_cntr_A;
  logic [BLK_W-1:0]       pixel_cntr_B;
  logic [K_W-1:0]         slice_cntr_B;
  logic [D_W_ACC*N*N-1:0] D;
  logic [N*N-1:0]         valid_D;

  modport master (
    output enable_row_count_A, A, B,
    input  pixel_cntr_A, slice_cntr_A, pixel_cntr_B, slice_cntr_B, D, valid_D
  );

  modport slave (
    input  enable_row_count_A, A, B,
    output pixel_cntr_A, slice_cntr_A, pixel_cntr_B, slice_cntr_B, D, valid_D
  );
endinterface

// File: rtl/systolic_array.sv
// Output-stationary NxN systolic MAC array computing C = A*B one NxN tile per M cycles.
// Define INPUT_SKEW_EN to skew the operand lanes internally instead of in the caller.
module systolic_array #(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 16,
  parameter int N       = 4,
  parameter int M       = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_array_if.slave bus
);
  localparam int K_W   = $clog2(M);
  localparam int BLK_W = $clog2(M / N);
  localparam int BLKS  = M / N;
  localparam int P_W   = 2 * D_W;

  logic [K_W-1:0]   pixel_a;
  logic [BLK_W-1:0] slice_a;
  logic [BLK_W-1:0] pixel_b;
  logic             k_last;
  // Bit d is high d cycles after the first cycle of a tile.
  logic [2*N-1:0]   start_pipe;

  assign k_last = (pixel_a == K_W'(M - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_a    <= '0;
      slice_a    <= '0;
      pixel_b    <= '0;
      start_pipe <= '0;
    end else begin
      // NOTE: every sequential update uses <= so all counters see pre-edge values.
      pixel_a    <= k_last ? '0 : pixel_a + K_W'(1);
      start_pipe <= {start_pipe[2*N-2:0], k_last};
      if (k_last)
        pixel_b <= (pixel_b == BLK_W'(BLKS - 1)) ? '0 : pixel_b + BLK_W'(1);
      if (bus.enable_row_count_A)
        slice_a <= (slice_a == BLK_W'(BLKS - 1)) ? '0 : slice_a + BLK_W'(1);
    end
  end

  assign bus.pixel_cntr_A = pixel_a;
  assign bus.slice_cntr_B = pixel_a;
  assign bus.slice_cntr_A = slice_a;
  assign bus.pixel_cntr_B = pixel_b;

  for (genvar gl = 0; gl < N; gl++) begin : g_lane
    logic [D_W-1:0] a_raw, b_raw, a_lane, b_lane;
    assign a_raw = bus.A[gl*D_W +: D_W];
    assign b_raw = bus.B[gl*D_W +: D_W];
`ifdef INPUT_SKEW_EN
    if (gl == 0) begin : g_direct
      assign a_lane = a_raw;
      assign b_lane = b_raw;
    end else begin : g_delay
      logic [D_W-1:0] a_sr [gl];
      logic [D_W-1:0] b_sr [gl];
      always_ff @(posedge clk) begin
        if (rst) begin
          // NOTE: every stage is cleared so an aborted tile leaves no stale operands.
          for (int s = 0; s < gl; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_raw;
          b_sr[0] <= b_raw;
          for (int s = 1; s < gl; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_lane = a_sr[gl-1];
      assign b_lane = b_sr[gl-1];
    end
`else
    assign a_lane = a_raw;
    assign b_lane = b_raw;
`endif
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [D_W-1:0]     a_op, b_op;
      logic [P_W-1:0]     prod;
      logic [D_W_ACC-1:0] acc, sum, d_reg;
      logic               valid_reg;
      logic               first, last;

      if (gj == 0) begin : g_a_edge
        assign a_op = g_lane[gi].a_lane;
      end else begin : g_a_inner
        assign a_op = g_row[gi].g_col[gj-1].g_a_fwd.a_reg;
      end
      if (gi == 0) begin : g_b_edge
        assign b_op = g_lane[gj].b_lane;
      end else begin : g_b_inner
        assign b_op = g_row[gi-1].g_col[gj].g_b_fwd.b_reg;
      end

      if (gj < N - 1) begin : g_a_fwd
        logic [D_W-1:0] a_reg;
        always_ff @(posedge clk) begin
          if (rst) a_reg <= '0;
          else     a_reg <= a_op;
        end
      end
      if (gi < N - 1) begin : g_b_fwd
        logic [D_W-1:0] b_reg;
        always_ff @(posedge clk) begin
          if (rst) b_reg <= '0;
          else     b_reg <= b_op;
        end
      end

      // first marks the k=0 term, last the k=M-1 term as they reach this PE.
      assign first = start_pipe[gi+gj+1];
      assign last  = start_pipe[gi+gj];
      assign prod  = P_W'(a_op) * P_W'(b_op);
      assign sum   = (first ? '0 : acc) + D_W_ACC'(prod);

      always_ff @(posedge clk) begin
        if (rst) begin
          acc       <= '0;
          d_reg     <= '0;
          valid_reg <= 1'b0;
        end else begin
          acc       <= sum;
          valid_reg <= last;
          if (last) d_reg <= sum;
        end
      end

      assign bus.D[D_W_ACC*(gi*N+gj) +: D_W_ACC] = d_reg;
      assign bus.valid_D[gi*N+gj]                 = valid_reg;
    end
  end
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: models operand memories, counters and
// per-tile results, and compares every output every cycle through a scoreboard.
module tb_systolic_array;
  localparam int D_W     = 8;
  localparam int D_W_ACC = 16;
  localparam int N       = 4;
  localparam int M       = 8;
  localparam int NN      = N * N;
  localparam int BLKS    = M / N;
  localparam int DW_TOT  = D_W_ACC * NN;
`ifdef INPUT_SKEW_EN
  localparam int CALLER_SKEW = 0;
`else
  localparam int CALLER_SKEW = 1;
`endif

  typedef struct packed {
    int                t0;
    logic [DW_TOT-1:0] d;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_array_if #(.D_W(D_W), .D_W_ACC(D_W_ACC), .N(N), .M(M)) bus ();

  systolic_array #(.D_W(D_W), .D_W_ACC(D_W_ACC), .N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int mat_a [M][M];
  int mat_b [M][M];
  int hist_pa [512];
  int hist_sa [512];
  int hist_pb [512];
  int t;
  int m_pa, m_sa, m_pb;
  tile_t sb [$];
  logic [DW_TOT-1:0] exp_d;
  int seq_r [4] = '{0, 0, 1, 1};
  int seq_c [4] = '{0, 1, 0, 1};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        case (mode)
          0:       begin mat_a[r][c] = (r == c) ? 1 : 0; mat_b[r][c] = r * 8 + c; end
          1:       begin mat_a[r][c] = 1;   mat_b[r][c] = 1;   end
          default: begin mat_a[r][c] = 255; mat_b[r][c] = 255; end
        endcase
      end
  endtask

  // Memory with one-cycle read latency; lane i delayed i cycles unless skewed inside.
  task automatic drive_inputs(input logic en);
    for (int i = 0; i < N; i++) begin
      int s;
      s = t - 1 - (CALLER_SKEW != 0 ? i : 0);
      if (s < 0) begin
        bus.A[i*D_W +: D_W] = '0;
        bus.B[i*D_W +: D_W] = '0;
      end else begin
        bus.A[i*D_W +: D_W] = D_W'(mat_a[hist_sa[s]*N+i][hist_pa[s]]);
        bus.B[i*D_W +: D_W] = D_W'(mat_b[hist_pa[s]][hist_pb[s]*N+i]);
      end
    end
    bus.enable_row_count_A = en;
  endtask

  task automatic push_tile();
    tile_t e;
    e.t0 = t - (M - 1);
    e.d  = '0;
    for (int p = 0; p < NN; p++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < M; k++)
        acc += mat_a[hist_sa[e.t0+k]*N + p/N][k] * mat_b[k][hist_pb[e.t0+k]*N + p%N];
      e.d[p*D_W_ACC +: D_W_ACC] = D_W_ACC'(acc);
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic en);
    logic [NN-1:0] exp_v;
    hist_pa[t] = m_pa;
    hist_sa[t] = m_sa;
    hist_pb[t] = m_pb;
    drive_inputs(en);
    if (m_pa == M - 1) push_tile();
    @(negedge clk);
    while (sb.size() > 0 && sb[0].t0 + M + 2*N - 1 < t) void'(sb.pop_front());
    exp_v = '0;
    foreach (sb[q])
      for (int p = 0; p < NN; p++)
        if (t == sb[q].t0 + M + 1 + p/N + p%N) begin
          exp_v[p] = 1'b1;
          exp_d[p*D_W_ACC +: D_W_ACC] = sb[q].d[p*D_W_ACC +: D_W_ACC];
        end
    check("valid_D", bus.valid_D, exp_v);
    check("D", bus.D, exp_d);
    check("pixel_cntr_A", bus.pixel_cntr_A, m_pa);
    check("slice_cntr_B", bus.slice_cntr_B, m_pa);
    check("pixel_cntr_B", bus.pixel_cntr_B, m_pb);
    check("slice_cntr_A", bus.slice_cntr_A, m_sa);
    @(posedge clk);
    #1;
    if (en) m_sa = (m_sa + 1) % BLKS;
    if (m_pa == M - 1) begin
      m_pa = 0;
      m_pb = (m_pb + 1) % BLKS;
    end else begin
      m_pa++;
    end
    t++;
  endtask

  // Leaves rst released at 1 time unit after the edge that starts c_0.
  task automatic do_reset();
    rst = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.enable_row_count_A = 1'b0;
    sb.delete();
    exp_d = '0;
    m_pa = 0;
    m_sa = 0;
    m_pb = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_D", bus.D, '0);
      check("rst_valid_D", bus.valid_D, '0);
      check("rst_pixel_cntr_A", bus.pixel_cntr_A, '0);
      check("rst_slice_cntr_A", bus.slice_cntr_A, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d observed=timeout expected=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    t = 0;

    // Identity A: each tile reproduces the matching B block.
    fill(0);
    do_reset();
    for (int c = 0; c < 4*M + 2*N + 2; c++) begin
      if (c % M == 0 && c / M < 4) begin
        check("tile_row_block", bus.slice_cntr_A, seq_r[c/M]);
        check("tile_col_block", bus.pixel_cntr_B, seq_c[c/M]);
      end
      step((c % (2*M)) == 2*M - 1);
    end

    // All ones: every element is M.
    fill(1);
    do_reset();
    for (int c = 0; c < 3*M + 2*N; c++) step(1'b0);
    check("ones_D_last", bus.D[DW_TOT-1 -: D_W_ACC], 16'd8);

    // All 255: accumulator wraps to 61448.
    fill(2);
    do_reset();
    for (int c = 0; c < 3*M + 2*N; c++) step(1'b0);
    check("wrap_D_first", bus.D[D_W_ACC-1:0], 16'd61448);
    check("wrap_D_last", bus.D[DW_TOT-1 -: D_W_ACC], 16'd61448);

    // Counter run: three-cycle hold then a single pulse.
    fill(1);
    do_reset();
    for (int c = 0; c < 4*M; c++) begin
      if (c == 8) check("hold3_slice_cntr_A", bus.slice_cntr_A, 1);
      step(c inside {5, 6, 7, 20});
    end
    check("final_slice_cntr_A", bus.slice_cntr_A, 0);

    // Abort the first tile in c_4 and restart.
    fill(0);
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b0);
    do_reset();
    for (int c = 0; c < 3*M + 2*N; c++) step(1'b0);
    check("abort_D00", bus.D[D_W_ACC-1:0], 16'd0);
    check("abort_D33", bus.D[DW_TOT-1 -: D_W_ACC], 16'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
